// File: rtl/dac_sender.sv
// Buffers 12-bit samples in a small FIFO and, on each sample_tick, shifts one
// 16-bit {CMD, sample} frame out to an SPI mode 0 DAC. Sticky flags report errors.
module dac_sender #(
  parameter int FIFO_DEPTH = 8,
  parameter int CLK_DIV = 2,
  parameter logic [3:0] CMD = 4'b0011
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [11:0]                   sample_in,
  input  logic                          new_sample_in,
  input  logic                          sample_tick,
  input  logic                          clear_flags,
  output logic                          dac_cs_n,
  output logic                          dac_sclk,
  output logic                          dac_mosi,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          underrun,
  output logic                          tick_missed
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [11:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [11:0]   last_sample;
  logic [1:0]    state;
  logic [CW-1:0] div_cnt;
  logic [4:0]    half_cnt;
  logic [14:0]   shreg;

  logic        fifo_empty;
  logic        fifo_full;
  logic        div_end;
  logic        can_start;
  logic        start;
  logic        pop;
  logic        push;
  logic [15:0] frame;

  // The last DONE cycle counts as idle so a tick exactly one frame period
  // after the previous one is accepted without a gap.
  always_comb begin
    fifo_empty = (fifo_level == '0);
    fifo_full  = (fifo_level == FULL_LEVEL);
    div_end    = (div_cnt == DIV_LAST);
    can_start  = (state == S_IDLE) || ((state == S_DONE) && div_end);
    start      = sample_tick && can_start;
    pop        = start && !fifo_empty;
    push       = new_sample_in && (!fifo_full || pop);
    frame      = {CMD, (pop ? mem[rd_ptr] : last_sample)};
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sample_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_level  <= '0;
      last_sample <= 12'h800;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr      <= rd_ptr + 1'b1;
        last_sample <= mem[rd_ptr];
      end
      if (push && !pop) fifo_level <= fifo_level + 1'b1;
      else if (pop && !push) fifo_level <= fifo_level - 1'b1;
    end
  end

  // A set event in the same cycle as clear_flags wins over the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow    <= 1'b0;
      underrun    <= 1'b0;
      tick_missed <= 1'b0;
    end else begin
      overflow    <= (overflow & ~clear_flags) | (new_sample_in & fifo_full & ~pop);
      underrun    <= (underrun & ~clear_flags) | (start & fifo_empty);
      tick_missed <= (tick_missed & ~clear_flags) | (sample_tick & ~can_start);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      div_cnt  <= '0;
      half_cnt <= '0;
      shreg    <= '0;
      dac_cs_n <= 1'b1;
      dac_sclk <= 1'b0;
      dac_mosi <= 1'b0;
      busy     <= 1'b1 ^ 1'b1;
    end else if (start) begin
      state    <= S_SETUP;
      div_cnt  <= '0;
      half_cnt <= '0;
      shreg    <= frame[14:0];
      dac_cs_n <= 1'b0;
      dac_sclk <= 1'b0;
      dac_mosi <= frame[15];
      busy     <= 1'b1;
    end else begin
      case (state)
        S_SETUP: begin
          if (div_end) begin
            div_cnt  <= '0;
            half_cnt <= '0;
            dac_sclk <= 1'b1;
            state    <= S_SHIFT;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        // Even half_cnt values are high half-periods, odd ones low; the 32nd
        // half is the trailing low phase before chip select is released.
        S_SHIFT: begin
          if (div_end) begin
            div_cnt <= '0;
            if (half_cnt == 5'd31) begin
              dac_cs_n <= 1'b1;
              state    <= S_DONE;
            end else begin
              half_cnt <= half_cnt + 1'b1;
              dac_sclk <= ~dac_sclk;
              if (dac_sclk && (half_cnt != 5'd30)) begin
                dac_mosi <= shreg[14];
                shreg    <= {shreg[13:0], 1'b0};
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (div_end) begin
            div_cnt <= '0;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: begin
          div_cnt <= '0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dac_sender.sv
// Scoreboard bench for dac_sender: a queue-based model predicts every frame,
// and a pin monitor decodes the SPI traffic and checks it against the queue.
module tb_dac_sender;

  localparam int DEPTH = 8;
  localparam int CD = 2;
  localparam int FRAME = 34 * CD;
  localparam logic [3:0] CMD = 4'b0011;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] sample_in = '0;
  logic        new_sample_in = 1'b0;
  logic        sample_tick = 1'b0;
  logic        clear_flags = 1'b0;
  logic        dac_cs_n;
  logic        dac_sclk;
  logic        dac_mosi;
  logic        busy;
  logic [3:0]  fifo_level;
  logic        overflow;
  logic        underrun;
  logic        tick_missed;

  always #5 clk = ~clk;

  dac_sender #(.FIFO_DEPTH(DEPTH), .CLK_DIV(CD), .CMD(CMD)) dut (
    .clk(clk), .rst(rst), .sample_in(sample_in), .new_sample_in(new_sample_in),
    .sample_tick(sample_tick), .clear_flags(clear_flags), .dac_cs_n(dac_cs_n),
    .dac_sclk(dac_sclk), .dac_mosi(dac_mosi), .busy(busy), .fifo_level(fifo_level),
    .overflow(overflow), .underrun(underrun), .tick_missed(tick_missed)
  );

  int total = 0;
  int bad = 0;

  // Reference model: sample queue, last sent sample, frame-busy window, flags.
  logic [11:0] mq[$];
  logic [15:0] exp_q[$];
  logic [11:0] m_last = 12'h800;
  bit          m_ovf = 0, m_und = 0, m_miss = 0;
  int          now = 0;
  int          free_at = 0;

  task automatic check_output(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, act, req);
    end
  endtask

  task automatic apply_stimulus(input bit push, input logic [11:0] val, input bit tick, input bit clr);
    logic [11:0] s;
    @(negedge clk);
    new_sample_in = push;
    sample_in     = val;
    sample_tick   = tick;
    clear_flags   = clr;
    if (clr) begin
      m_ovf = 0; m_und = 0; m_miss = 0;
    end
    if (tick) begin
      if (now >= free_at) begin
        if (mq.size() == 0) begin
          m_und = 1;
          s = m_last;
        end else begin
          s = mq.pop_front();
          m_last = s;
        end
        exp_q.push_back({CMD, s});
        free_at = now + FRAME;
      end else begin
        m_miss = 1;
      end
    end
    if (push) begin
      if (mq.size() < DEPTH) mq.push_back(val);
      else m_ovf = 1;
    end
    @(posedge clk);
    #1;
    now++;
    new_sample_in = 0;
    sample_tick   = 0;
    clear_flags   = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) apply_stimulus(0, 12'h000, 0, 0);
  endtask

  task automatic check_state(input string tag);
    check_output({tag, "_level"}, int'(fifo_level), mq.size());
    check_output({tag, "_overflow"}, int'(overflow), int'(m_ovf));
    check_output({tag, "_underrun"}, int'(underrun), int'(m_und));
    check_output({tag, "_tick_missed"}, int'(tick_missed), int'(m_miss));
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    while (exp_q.size() != 0 && guard < 3000) begin
      idle(1);
      guard++;
    end
    idle(4);
    check_output({tag, "_drain"}, exp_q.size(), 0);
  endtask

  // Pin monitor: decodes MOSI on SCLK rises and checks frame timing.
  logic [15:0] cap = '0;
  int          nbits = 0, cs_len = 0, busy_len = 0;
  bit          prev_sclk = 0, prev_cs = 1, prev_busy = 0;
  logic [15:0] e;

  always @(negedge clk) begin
    if (rst) begin
      nbits = 0; cs_len = 0; busy_len = 0;
      prev_sclk = 0; prev_cs = 1; prev_busy = 0;
    end else begin
      if (dac_sclk && !prev_sclk) begin
        cap = {cap[14:0], dac_mosi};
        nbits++;
      end
      if (!dac_cs_n) cs_len++;
      if (dac_cs_n && !prev_cs) begin
        check_output("frame_pending", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_output("frame_data", int'(cap), int'(e));
        end
        check_output("frame_bits", nbits, 16);
        check_output("cs_low_cycles", cs_len, 33 * CD);
        nbits = 0;
        cs_len = 0;
      end
      if (busy) busy_len++;
      if (!busy && prev_busy) begin
        check_output("busy_cycles", busy_len % FRAME, 0);
        busy_len = 0;
      end
      prev_sclk = dac_sclk;
      prev_cs   = dac_cs_n;
      prev_busy = busy;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, wanted completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [11:0] v;
    #12;
    check_output("reset_cs_n", int'(dac_cs_n), 1);
    check_output("reset_sclk", int'(dac_sclk), 0);
    check_output("reset_mosi", int'(dac_mosi), 0);
    check_output("reset_busy", int'(busy), 0);
    check_state("reset");
    @(negedge clk);
    rst = 0;
    idle(2);

    // Underrun right after reset sends midscale, then a real sample.
    apply_stimulus(0, 12'h000, 1, 0);
    idle(2);
    check_output("tick_busy", int'(busy), 1);
    check_output("tick_cs_n", int'(dac_cs_n), 0);
    idle(75);
    check_state("underrun");
    apply_stimulus(1, 12'h001, 0, 0);
    apply_stimulus(0, 12'h000, 1, 0);
    idle(75);
    apply_stimulus(0, 12'h000, 0, 1);
    check_state("clear1");

    // Single frame with level tracking.
    apply_stimulus(1, 12'hABC, 0, 0);
    check_output("single_level1", int'(fifo_level), 1);
    apply_stimulus(0, 12'h000, 1, 0);
    check_output("single_level0", int'(fifo_level), 0);
    idle(75);
    check_state("single");

    // Overflow: nine pushes into an eight-deep FIFO, then eight frames.
    for (int i = 1; i <= 9; i++) apply_stimulus(1, 12'(i), 0, 0);
    check_state("overflow");
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(0, 12'h000, 1, 0);
      idle(75);
    end
    check_state("overflow_drained");
    apply_stimulus(0, 12'h000, 0, 1);

    // Missed tick: second tick 10 cycles into the frame.
    apply_stimulus(1, 12'h123, 0, 0);
    apply_stimulus(0, 12'h000, 1, 0);
    idle(9);
    apply_stimulus(0, 12'h000, 1, 0);
    check_state("missed");
    idle(70);
    apply_stimulus(0, 12'h000, 0, 1);
    check_state("missed_clear");

    // Push and pop together while full.
    for (int i = 0; i < 8; i++) apply_stimulus(1, 12'($urandom_range(0, 4095)), 0, 0);
    v = 12'($urandom_range(0, 4095));
    apply_stimulus(1, v, 1, 0);
    check_state("full_pushpop");
    idle(75);
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(0, 12'h000, 1, 0);
      idle(75);
    end
    check_state("full_drained");

    // Random traffic, including ticks that land inside a frame.
    for (int i = 0; i < 14; i++) begin
      repeat ($urandom_range(0, 3)) apply_stimulus(1, 12'($urandom_range(0, 4095)), 0, 0);
      idle($urandom_range(0, 80));
      apply_stimulus($urandom_range(0, 1) == 1, 12'($urandom_range(0, 4095)), 1,
                     $urandom_range(0, 3) == 0);
      check_state("random");
    end
    drain("random");

    // Reset during the 5th SCLK period abandons the frame.
    apply_stimulus(1, 12'h5A5, 0, 0);
    apply_stimulus(0, 12'h000, 1, 0);
    idle(19);
    #2 rst = 1;
    #1;
    check_output("midreset_cs_n", int'(dac_cs_n), 1);
    check_output("midreset_sclk", int'(dac_sclk), 0);
    check_output("midreset_busy", int'(busy), 0);
    check_output("midreset_level", int'(fifo_level), 0);
    exp_q.delete();
    mq.delete();
    m_last = 12'h800;
    m_ovf = 0; m_und = 0; m_miss = 0;
    free_at = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    idle(2);
    apply_stimulus(0, 12'h000, 1, 0);
    drain("after_reset");
    check_state("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
